lcd_cmd_arbiter: RTL and testbench
==================================

// Module: lcd_cmd_arbiter
// PURPOSE
// Shares the single PMOD CLS LCD driver command port (clear / write line 1 / write line 2) between
// parm_num_req requesters, e.g. the periodic text feed and a fault/status overlay. Round-robin grant per
// command, optional lock so one owner completes a clear+line1+line2 sequence, 128-bit text mux, and an
// issue timeout if the driver never acknowledges. Sits between requesters and the LCD SPI driver.
// PARAMETERS
// parm_num_req      2     number of requesters, legal 2..4; index 0 = requester 0
// parm_timeout      2500  CE ticks in ST_ISSUE without i_lcd_command_ready falling before abort (~1 ms)
// parm_max_lock     3     max consecutive commands one owner may hold via lock before forced rotation
// PORTS
// i_clk_20mhz            in   1      system clock, 20 MHz
// i_rstn_20mhz           in   1      asynchronous reset, active-low
// i_ce_2_5mhz            in   1      clock enable; all state/counter updates only on edges with CE=1
// i_req_valid            in   N      requester i has a command pending (level, held until ack)
// i_req_cmd              in   2*N    cmd of req i at [2i+1:2i]: 01 clear, 10 line1, 11 line2, 00 none
// i_req_lock             in   N      req i wants to keep grant after its current command completes
// i_req_text_line1       in   128*N  16-char ASCII line 1 of req i at [128i+127:128i]
// i_req_text_line2       in   128*N  16-char ASCII line 2 of req i
// i_lcd_command_ready    in   1      driver idle / ready for a command
// o_lcd_wr_clear_display out  1      strobe to driver, held in ST_ISSUE when granted cmd = 01
// o_lcd_wr_text_line1    out  1      strobe, held in ST_ISSUE when cmd = 10
// o_lcd_wr_text_line2    out  1      strobe, held in ST_ISSUE when cmd = 11
// o_lcd_text_line1       out  128    line 1 text captured from owner at grant; stable until next grant
// o_lcd_text_line2       out  128    line 2 text captured from owner at grant
// o_req_ack              out  N      one-hot; bit of owner high for exactly one CE period in ST_DONE
// o_req_grant            out  N      one-hot owner while not ST_IDLE; 0 in ST_IDLE
// o_err_timeout          out  1      high for one CE period (ST_ABORT) after an issue timeout
// BEHAVIOUR
// - Reset (async, rstn=0): state ST_IDLE, all outputs 0, text regs 0, owner = N-1 (req 0 wins first),
//   timer 0, lock_cnt 0. Reset mid-command drops strobes immediately; no ack emitted.
// - Valid request: i_req_valid[i]=1 and cmd!=00; valid with cmd=00 is ignored.
// - ST_IDLE: on CE, pick first valid i scanning owner+1, owner+2 ... mod N; register owner, cmd, both text
//   lines; go ST_ISSUE. No valid -> stay. Strobe appears on the edge entering ST_ISSUE (1 CE latency).
// - ST_ISSUE: strobe per latched cmd; timer counts per CE. i_lcd_command_ready=0 -> ST_BUSY.
//   Timer reaches parm_timeout-1 with ready still 1 -> ST_ABORT.
// - ST_BUSY: strobes 0; wait i_lcd_command_ready=1 -> ST_DONE (no timeout here; driver bounds it).
// - ST_DONE: o_req_ack[owner]=1 for one CE period. Next: if i_req_lock[owner]=1 and lock_cnt <
//   parm_max_lock-1 and owner has a valid request -> latch its new cmd/text, lock_cnt++, ST_ISSUE
//   (owner kept, no arbitration). Else lock_cnt=0, ST_IDLE (round robin resumes after owner).
// - ST_ABORT: o_err_timeout=1 one CE period, no ack, lock_cnt=0, -> ST_IDLE; owner kept as last granted so
//   the failing requester is rotated to lowest priority.
// - Timer: clears on every state change; saturates, never wraps. Width = $clog2(parm_timeout+1).
// - Requester must hold valid/cmd/text stable until ack; changes after grant are not seen (latched).
// - Requester dropping valid mid-command: command still completes and ack is still pulsed.
// - All outputs registered or decoded from registered state; no combinational path input->output.
// TESTING
// - Single req0 cmd=01, driver drops ready 2 CE after strobe then raises 5 CE later -> clear strobe 2 CE,
//   ack[0] 1 CE, back to IDLE.
// - req0,req1 both valid cmd=10 continuously, no lock -> grants alternate 0,1,0,1; texts follow owner.
// - req1 lock=1 issuing 01,10,11,01 with req0 waiting -> req1 gets 3 commands, then req0 granted, then req1.
// - Driver never drops ready, parm_timeout=8 -> strobe exactly 8 CE, o_err_timeout 1 CE, no ack, other req next.
// - Assert rstn=0 during ST_BUSY -> all outputs 0 same cycle; after release req0 granted first.
// - valid=1 with cmd=00 on req0 and cmd=11 on req1 -> only req1 granted, line2 strobe only.

Source files
------------

// File: rtl/lcd_cmd_arbiter_if.sv
// Requester/driver bundle for the LCD command arbiter: N requester command ports on one side,
// the single PMOD CLS driver command port on the other.
interface lcd_cmd_arbiter_if #(
    parameter int parm_num_req = 2
);
    logic [parm_num_req-1:0]       i_req_valid;
    logic [2*parm_num_req-1:0]     i_req_cmd;
    logic [parm_num_req-1:0]       i_req_lock;
    logic [128*parm_num_req-1:0]   i_req_text_line1;
    logic [128*parm_num_req-1:0]   i_req_text_line2;
    logic                          i_lcd_command_ready;

    logic                          o_lcd_wr_clear_display;
    logic                          o_lcd_wr_text_line1;
    logic                          o_lcd_wr_text_line2;
    logic [127:0]                  o_lcd_text_line1;
    logic [127:0]                  o_lcd_text_line2;
    logic [parm_num_req-1:0]       o_req_ack;
    logic [parm_num_req-1:0]       o_req_grant;
    logic                          o_err_timeout;

    modport master (
        output i_req_valid, i_req_cmd, i_req_lock, i_req_text_line1, i_req_text_line2,
        output i_lcd_command_ready,
        input  o_lcd_wr_clear_display, o_lcd_wr_text_line1, o_lcd_wr_text_line2,
        input  o_lcd_text_line1, o_lcd_text_line2, o_req_ack, o_req_grant, o_err_timeout
    );

    modport slave (
        input  i_req_valid, i_req_cmd, i_req_lock, i_req_text_line1, i_req_text_line2,
        input  i_lcd_command_ready,
        output o_lcd_wr_clear_display, o_lcd_wr_text_line1, o_lcd_wr_text_line2,
        output o_lcd_text_line1, o_lcd_text_line2, o_req_ack, o_req_grant, o_err_timeout
    );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter sharing the LCD driver command port between requesters, with optional
// multi-command lock per owner and an issue timeout when the driver never accepts a strobe.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no owner; scan requesters starting after the last owner
// ST_ISSUE | strobe for latched cmd held; waiting for ready to fall
// ST_BUSY  | driver executing; waiting for ready to rise
// ST_DONE  | ack pulse to owner; optionally keep grant for locked owner
// ST_ABORT | driver never took the command; error pulse, no ack
module lcd_cmd_arbiter #(
    parameter int parm_num_req  = 2,
    parameter int parm_timeout  = 2500,
    parameter int parm_max_lock = 3
) (
    input  logic              i_clk_20mhz,
    input  logic              i_rstn_20mhz,
    input  logic              i_ce_2_5mhz,
    lcd_cmd_arbiter_if.slave  bus
);
    localparam int OW = $clog2(parm_num_req);
    localparam int TW = $clog2(parm_timeout + 1);
    localparam int LW = $clog2(parm_max_lock + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DONE,
        ST_ABORT
    } state_t;

    state_t                state_q, state_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [127:0]          text1_q, text1_d;
    logic [127:0]          text2_q, text2_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [LW-1:0]         lock_cnt_q, lock_cnt_d;

    logic [parm_num_req-1:0] req_ok;
    logic                    pick_found;
    logic [OW-1:0]           pick_idx;
    logic [OW-1:0]           sel_idx;
    logic [1:0]              sel_cmd;
    logic [127:0]            sel_text1;
    logic [127:0]            sel_text2;
    logic                    lock_keep;
    logic [parm_num_req-1:0] grant;
    logic [parm_num_req-1:0] ack;

    always_comb begin
        for (int i = 0; i < parm_num_req; i++) begin
            req_ok[i] = bus.i_req_valid[i] && (bus.i_req_cmd[2*i +: 2] != 2'b00);
        end
    end

    // Scan owner+1 .. owner+N so the last owner ends up with the lowest priority.
    always_comb begin
        int j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int k = 1; k <= parm_num_req; k++) begin
            j = (int'(owner_q) + k) % parm_num_req;
            if (!pick_found && req_ok[j]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(j);
            end
        end
    end

    assign sel_idx   = (state_q == ST_DONE) ? owner_q : pick_idx;
    assign sel_cmd   = bus.i_req_cmd[2*sel_idx +: 2];
    assign sel_text1 = bus.i_req_text_line1[128*sel_idx +: 128];
    assign sel_text2 = bus.i_req_text_line2[128*sel_idx +: 128];

    assign lock_keep = bus.i_req_lock[owner_q] && req_ok[owner_q]
                       && (lock_cnt_q < LW'(parm_max_lock - 1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        text1_d    = text1_q;
        text2_d    = text2_q;
        timer_d    = timer_q;
        lock_cnt_d = lock_cnt_q;
        if (i_ce_2_5mhz) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_d = ST_ISSUE;
                        owner_d = pick_idx;
                        cmd_d   = sel_cmd;
                        text1_d = sel_text1;
                        text2_d = sel_text2;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.i_lcd_command_ready) begin
                        state_d = ST_BUSY;
                    end else if (timer_q == TW'(parm_timeout - 1)) begin
                        state_d = ST_ABORT;
                    end
                end
                ST_BUSY: begin
                    if (bus.i_lcd_command_ready) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (lock_keep) begin
                        state_d    = ST_ISSUE;
                        cmd_d      = sel_cmd;
                        text1_d    = sel_text1;
                        text2_d    = sel_text2;
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        lock_cnt_d = '0;
                    end
                end
                ST_ABORT: begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // DONE->ISSUE under lock is also a state change, so each command gets a fresh timeout.
            if (state_d != state_q) begin
                timer_d = '0;
            end else if (state_q == ST_ISSUE && timer_q != '1) begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q    <= ST_IDLE;
            owner_q    <= OW'(parm_num_req - 1);
            cmd_q      <= 2'b00;
            text1_q    <= '0;
            text2_q    <= '0;
            timer_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            text1_q    <= text1_d;
            text2_q    <= text2_d;
            timer_q    <= timer_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        grant = '0;
        ack   = '0;
        if (state_q != ST_IDLE) begin
            grant[owner_q] = 1'b1;
        end
        if (state_q == ST_DONE) begin
            ack[owner_q] = 1'b1;
        end
    end

    assign bus.o_req_grant            = grant;
    assign bus.o_req_ack              = ack;
    assign bus.o_lcd_wr_clear_display = (state_q == ST_ISSUE) && (cmd_q == 2'b01);
    assign bus.o_lcd_wr_text_line1    = (state_q == ST_ISSUE) && (cmd_q == 2'b10);
    assign bus.o_lcd_wr_text_line2    = (state_q == ST_ISSUE) && (cmd_q == 2'b11);
    assign bus.o_lcd_text_line1       = text1_q;
    assign bus.o_lcd_text_line2       = text2_q;
    assign bus.o_err_timeout          = (state_q == ST_ABORT);
endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter: two requesters, 8-tick timeout, lock limit of 3 commands.
module tb_lcd_cmd_arbiter;
    localparam int N = 2;

    localparam logic [127:0] T_A  = "CLEAR SCREEN 000";
    localparam logic [127:0] T_B  = "SECOND LINE  000";
    localparam logic [127:0] T_X  = "CHANGED LATE 999";
    localparam logic [127:0] T_R0 = "FEED REQ0 LINE 1";
    localparam logic [127:0] T_R1 = "FAULT REQ1 LN 1 ";
    localparam logic [127:0] T_S0 = "FEED REQ0 LINE 2";
    localparam logic [127:0] T_S1 = "FAULT REQ1 LN 2 ";
    localparam logic [127:0] T_Y1 = "LOCK SEQ CMD 01 ";
    localparam logic [127:0] T_Y2 = "LOCK SEQ CMD 02 ";
    localparam logic [127:0] T_Y3 = "LOCK SEQ CMD 03 ";
    localparam logic [127:0] T_Y4 = "LOCK SEQ CMD 04 ";
    localparam logic [127:0] T_W  = "WAITING REQ0 TXT";
    localparam logic [127:0] T_Z  = "AFTER RESET TXT ";

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce = 1'b0;
    logic [1:0] div = 2'd0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cnt;

    always #25 clk = ~clk;

    always @(negedge clk) begin
        div = div + 2'd1;
        ce  = (div == 2'd0);
    end

    lcd_cmd_arbiter_if #(.parm_num_req(N)) bus ();

    lcd_cmd_arbiter #(
        .parm_num_req (N),
        .parm_timeout (8),
        .parm_max_lock(3)
    ) dut (
        .i_clk_20mhz (clk),
        .i_rstn_20mhz(rst_n),
        .i_ce_2_5mhz (ce),
        .bus         (bus)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [2:0] exp_strobe(input logic [1:0] c);
        case (c)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] strobes();
        return {bus.o_lcd_wr_text_line2, bus.o_lcd_wr_text_line1, bus.o_lcd_wr_clear_display};
    endfunction

    task automatic ce_tick();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            if (ce) break;
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] c, input logic l,
                           input logic [127:0] t1, input logic [127:0] t2);
        bus.i_req_valid[i]                = v;
        bus.i_req_cmd[2*i +: 2]           = c;
        bus.i_req_lock[i]                 = l;
        bus.i_req_text_line1[128*i +: 128] = t1;
        bus.i_req_text_line2[128*i +: 128] = t2;
    endtask

    // Called just after the edge that entered ISSUE; returns one tick into DONE.
    task automatic run_cmd(input string tag, input logic [1:0] o_grant, input logic [1:0] c,
                           input logic [127:0] t1, input logic [127:0] t2);
        check_val({tag, "_grant"}, bus.o_req_grant, o_grant);
        check_val({tag, "_strobe"}, strobes(), exp_strobe(c));
        check_val({tag, "_text1"}, bus.o_lcd_text_line1, t1);
        check_val({tag, "_text2"}, bus.o_lcd_text_line2, t2);
        bus.i_lcd_command_ready = 1'b0;
        ce_tick();
        check_val({tag, "_busy_strobe"}, strobes(), 3'b000);
        bus.i_lcd_command_ready = 1'b1;
        ce_tick();
        check_val({tag, "_ack"}, bus.o_req_ack, o_grant);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_cmd = '0;
        bus.i_req_lock = '0;
        bus.i_req_text_line1 = '0;
        bus.i_req_text_line2 = '0;
        bus.i_lcd_command_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_grant", bus.o_req_grant, 2'b00);
        check_val("rst_ack", bus.o_req_ack, 2'b00);
        check_val("rst_strobe", strobes(), 3'b000);
        check_val("rst_err", bus.o_err_timeout, 1'b0);
        check_val("rst_text1", bus.o_lcd_text_line1, 128'd0);
        rst_n = 1'b1;

        // Single clear from req0: 2-tick strobe, 5-tick busy, one ack, text latched at grant.
        set_req(0, 1'b1, 2'b01, 1'b0, T_A, T_B);
        ce_tick();
        check_val("t1_grant", bus.o_req_grant, 2'b01);
        check_val("t1_strobe0", strobes(), 3'b001);
        check_val("t1_text1", bus.o_lcd_text_line1, T_A);
        check_val("t1_text2", bus.o_lcd_text_line2, T_B);
        bus.i_req_text_line1[127:0] = T_X;
        ce_tick();
        check_val("t1_strobe1", strobes(), 3'b001);
        check_val("t1_latched", bus.o_lcd_text_line1, T_A);
        bus.i_lcd_command_ready = 1'b0;
        ce_tick();
        check_val("t1_busy_strobe", strobes(), 3'b000);
        repeat (4) begin
            ce_tick();
            check_val("t1_busy_ack", bus.o_req_ack, 2'b00);
        end
        bus.i_lcd_command_ready = 1'b1;
        ce_tick();
        check_val("t1_ack", bus.o_req_ack, 2'b01);
        bus.i_req_valid[0] = 1'b0;
        ce_tick();
        check_val("t1_ack_gone", bus.o_req_ack, 2'b00);
        check_val("t1_idle_grant", bus.o_req_grant, 2'b00);

        // Both want line1 continuously; last owner was 0, so grants run 1,0,1,0.
        set_req(0, 1'b1, 2'b10, 1'b0, T_R0, T_S0);
        set_req(1, 1'b1, 2'b10, 1'b0, T_R1, T_S1);
        for (int k = 0; k < 4; k++) begin
            ce_tick();
            if (k % 2 == 0) run_cmd("rr_req1", 2'b10, 2'b10, T_R1, T_S1);
            else            run_cmd("rr_req0", 2'b01, 2'b10, T_R0, T_S0);
            ce_tick();
            check_val("rr_idle", bus.o_req_grant, 2'b00);
        end

        // req1 locks through four commands; lock limit forces req0 in after three.
        set_req(0, 1'b1, 2'b10, 1'b0, T_W, T_S0);
        set_req(1, 1'b1, 2'b01, 1'b1, T_Y1, T_S1);
        ce_tick();
        run_cmd("lk_c1", 2'b10, 2'b01, T_Y1, T_S1);
        set_req(1, 1'b1, 2'b10, 1'b1, T_Y2, T_S1);
        ce_tick();
        run_cmd("lk_c2", 2'b10, 2'b10, T_Y2, T_S1);
        set_req(1, 1'b1, 2'b11, 1'b1, T_Y3, T_S1);
        ce_tick();
        run_cmd("lk_c3", 2'b10, 2'b11, T_Y3, T_S1);
        set_req(1, 1'b1, 2'b01, 1'b1, T_Y4, T_S1);
        ce_tick();
        check_val("lk_forced_idle", bus.o_req_grant, 2'b00);
        ce_tick();
        run_cmd("lk_req0", 2'b01, 2'b10, T_W, T_S0);
        bus.i_req_valid[0] = 1'b0;
        ce_tick();
        ce_tick();
        run_cmd("lk_c4", 2'b10, 2'b01, T_Y4, T_S1);
        set_req(1, 1'b0, 2'b00, 1'b0, T_Y4, T_S1);
        ce_tick();

        // Ready never falls: strobe for exactly 8 ticks, error pulse, no ack, req1 next.
        set_req(0, 1'b1, 2'b10, 1'b0, T_R0, T_S0);
        set_req(1, 1'b1, 2'b11, 1'b0, T_R1, T_S1);
        ce_tick();
        check_val("to_grant", bus.o_req_grant, 2'b01);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (strobes() == 3'b000) break;
            cnt++;
            ce_tick();
        end
        check_val("to_strobe_len", cnt, 8);
        check_val("to_err", bus.o_err_timeout, 1'b1);
        check_val("to_no_ack", bus.o_req_ack, 2'b00);
        ce_tick();
        check_val("to_err_gone", bus.o_err_timeout, 1'b0);
        ce_tick();
        run_cmd("to_next", 2'b10, 2'b11, T_R1, T_S1);
        bus.i_req_valid = '0;
        ce_tick();

        // cmd=00 on req0 is not a request even though it is scanned first.
        set_req(0, 1'b1, 2'b00, 1'b0, T_W, T_W);
        set_req(1, 1'b1, 2'b11, 1'b0, T_Y3, T_Y4);
        ce_tick();
        run_cmd("nop_req1", 2'b10, 2'b11, T_Y3, T_Y4);
        bus.i_req_valid[1] = 1'b0;
        ce_tick();
        ce_tick();
        check_val("nop_ignored", bus.o_req_grant, 2'b00);

        // Reset during BUSY clears outputs at once; req0 wins first afterwards.
        set_req(0, 1'b0, 2'b00, 1'b0, T_W, T_W);
        set_req(1, 1'b1, 2'b10, 1'b0, T_R1, T_S1);
        ce_tick();
        bus.i_lcd_command_ready = 1'b0;
        ce_tick();
        check_val("rb_busy_grant", bus.o_req_grant, 2'b10);
        #10;
        rst_n = 1'b0;
        #1;
        check_val("rb_grant", bus.o_req_grant, 2'b00);
        check_val("rb_strobe", strobes(), 3'b000);
        check_val("rb_ack", bus.o_req_ack, 2'b00);
        check_val("rb_text1", bus.o_lcd_text_line1, 128'd0);
        set_req(0, 1'b1, 2'b01, 1'b0, T_Z, T_B);
        bus.i_lcd_command_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        ce_tick();
        run_cmd("rb_req0", 2'b01, 2'b01, T_Z, T_B);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
